// File: rtl/s247_gps_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : s247_gps_pkg                                              |
// | Brief    : Shared constants and types for the GPS serial ingest.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package s247_gps_pkg;

  // Frame preamble and the only accepted payload length
  localparam logic [7:0] SYNC0     = 8'hA5;
  localparam logic [7:0] SYNC1     = 8'h5A;
  localparam logic [7:0] FRAME_LEN = 8'h08;

  // Packet parser states
  typedef enum logic [2:0] {
    ST_HUNT0   = 3'd0,
    ST_HUNT1   = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } parser_state_t;

  // Q16.16 signed coordinate
  typedef logic signed [31:0] coord_t;

endpackage
`default_nettype wire

// File: rtl/s247_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : s247_uart_rx                                              |
// | Brief    : 8N1 UART receiver: synchronizer, bit timer, LSB-first     |
// |            shifter. Emits a byte strobe or a framing-error strobe.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module s247_uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int            CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  logic          r_sync0;
  logic          r_sync1;
  logic          r_rx_d;
  rx_state_t     r_state;
  rx_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_vld;
  logic          w_vld_nxt;
  logic          r_ferr;
  logic          w_ferr_nxt;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync0 <= rx_i;
      r_sync1 <= r_sync0;
      r_rx_d  <= r_sync1;
    end
  end

  // Receiver state, bit timer, shifter and output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_vld   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_vld   <= w_vld_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // Next-state: start bit re-checked at mid-bit, data and stop sampled at bit centres
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_vld_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (r_rx_d && !r_sync1) begin
          w_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          // A line that is already high again was only a glitch
          w_state_nxt = r_sync1 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_sync1, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = RX_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_vld_nxt   = r_sync1;
          w_ferr_nxt  = !r_sync1;
          w_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  assign byte_o      = r_shift;
  assign byte_vld_o  = r_vld;
  assign frame_err_o = r_ferr;

endmodule
`default_nettype wire

// File: rtl/s247_gps_ingest.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : s247_gps_ingest                                           |
// | Brief    : GPS serial front end. Frames and checksums position       |
// |            packets, holds the last good Q16.16 lat/lon, counts       |
// |            rejected frames and flags a stale fix.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module s247_gps_ingest
  import s247_gps_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 8 * CLKS_PER_BIT * 10,
  parameter int STALE_CYCLES   = 50_000_000,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] gps_lat,
  output logic [DATA_WIDTH-1:0] gps_lon,
  output logic                  fix_valid,
  output logic                  stale,
  output logic [7:0]            frame_err_cnt
);

  localparam int            TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam int            SW          = $clog2(STALE_CYCLES + 1);
  localparam logic [TW-1:0] C_TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] C_STALE_MAX = SW'(STALE_CYCLES);

  logic [7:0]    w_byte;
  logic          w_byte_vld;
  logic          w_frame_err;

  parser_state_t r_state;
  parser_state_t w_state_nxt;
  logic [2:0]    r_idx;
  logic [7:0]    r_xor;
  logic [63:0]   r_stage;
  coord_t        r_lat;
  coord_t        r_lon;
  logic          r_fix;
  logic [7:0]    r_err_cnt;
  logic [TW-1:0] r_tmo;
  logic [SW-1:0] r_stale;

  logic          w_tmo_hit;
  logic          w_err_evt;
  logic          w_good_evt;
  logic          w_payload_evt;
  logic          w_len_ok;

  s247_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .byte_o      (w_byte),
    .byte_vld_o  (w_byte_vld),
    .frame_err_o (w_frame_err)
  );

  // Parser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Parser next-state and per-cycle events; at most one event per cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_err_evt     = 1'b0;
    w_good_evt    = 1'b0;
    w_payload_evt = 1'b0;
    w_len_ok      = 1'b0;
    w_tmo_hit     = (r_state != ST_HUNT0) && !w_byte_vld && !w_frame_err &&
                    (r_tmo == C_TMO_LAST);
    if (w_frame_err || w_tmo_hit) begin
      w_state_nxt = ST_HUNT0;
      w_err_evt   = 1'b1;
    end else if (w_byte_vld) begin
      case (r_state)
        ST_HUNT0: begin
          if (w_byte == SYNC0) w_state_nxt = ST_HUNT1;
        end
        ST_HUNT1: begin
          // A repeated first sync byte keeps us aligned on the newer one
          if (w_byte == SYNC1)      w_state_nxt = ST_LEN;
          else if (w_byte != SYNC0) w_state_nxt = ST_HUNT0;
        end
        ST_LEN: begin
          if (w_byte == FRAME_LEN) begin
            w_state_nxt = ST_PAYLOAD;
            w_len_ok    = 1'b1;
          end else begin
            w_state_nxt = ST_HUNT0;
            w_err_evt   = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          w_payload_evt = 1'b1;
          if (r_idx == 3'd7) w_state_nxt = ST_CSUM;
        end
        ST_CSUM: begin
          w_state_nxt = ST_HUNT0;
          if (w_byte == r_xor) w_good_evt = 1'b1;
          else                 w_err_evt  = 1'b1;
        end
        default: begin
          w_state_nxt = ST_HUNT0;
        end
      endcase
    end
  end

  // Payload staging: big-endian shift-in with running XOR checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_xor   <= '0;
      r_stage <= '0;
    end else if (w_len_ok) begin
      r_idx <= '0;
      r_xor <= '0;
    end else if (w_payload_evt) begin
      r_idx   <= r_idx + 3'd1;
      r_xor   <= r_xor ^ w_byte;
      r_stage <= {r_stage[55:0], w_byte};
    end
  end

  // Coordinate outputs: both halves load on the same edge so a fix is never torn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat <= '0;
      r_lon <= '0;
      r_fix <= 1'b0;
    end else begin
      r_fix <= w_good_evt;
      if (w_good_evt) begin
        r_lat <= r_stage[63:32];
        r_lon <= r_stage[31:0];
      end
    end
  end

  // Saturating rejected-frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Inter-byte gap timer, idle while hunting for the first sync byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if ((r_state == ST_HUNT0) || w_byte_vld || w_frame_err) begin
      r_tmo <= '0;
    end else if (r_tmo != C_TMO_LAST) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // Age of the last good fix; starts saturated so the fix reads stale from reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stale <= C_STALE_MAX;
    end else if (w_good_evt) begin
      r_stale <= '0;
    end else if (r_stale != C_STALE_MAX) begin
      r_stale <= r_stale + 1'b1;
    end
  end

  assign gps_lat       = r_lat;
  assign gps_lon       = r_lon;
  assign fix_valid     = r_fix;
  assign stale         = (r_stale == C_STALE_MAX);
  assign frame_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_s247_gps_ingest.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_s247_gps_ingest                                        |
// | Brief    : Directed self-checking bench for s247_gps_ingest.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_s247_gps_ingest;

  localparam int CPB = 4;
  localparam int TMO = 200;
  localparam int STL = 1000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_i  = 1'b1;
  logic [31:0] gps_lat;
  logic [31:0] gps_lon;
  logic        fix_valid;
  logic        stale;
  logic [7:0]  frame_err_cnt;

  int total = 0;
  int bad   = 0;

  int   cyc          = 0;
  int   fix_cnt      = 0;
  int   fix_cyc      = 0;
  int   rise_cyc     = 0;
  logic stale_at_fix = 1'b1;
  logic stale_prev   = 1'b1;

  always #5 clk = ~clk;

  s247_gps_ingest #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TMO),
    .STALE_CYCLES   (STL),
    .DATA_WIDTH     (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_i          (rx_i),
    .gps_lat       (gps_lat),
    .gps_lon       (gps_lon),
    .fix_valid     (fix_valid),
    .stale         (stale),
    .frame_err_cnt (frame_err_cnt)
  );

  // Pulse counter and cycle stamps for fix_valid and stale rising edges
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    stale_prev <= stale;
    if (fix_valid) begin
      fix_cnt      <= fix_cnt + 1;
      fix_cyc      <= cyc;
      stale_at_fix <= stale;
    end
    if (stale && !stale_prev) rise_cyc <= cyc;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] lat, input logic [31:0] lon, input logic [7:0] cs);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h08, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(lat[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(lon[i*8 +: 8], 1'b1);
    send_byte(cs, 1'b1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (5) @(negedge clk);
    chk("rst_lat",   gps_lat, 32'h0);
    chk("rst_lon",   gps_lon, 32'h0);
    chk("rst_fix",   {31'b0, fix_valid}, 32'h0);
    chk("rst_stale", {31'b0, stale}, 32'h1);
    chk("rst_err",   {24'b0, frame_err_cnt}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame A: +1.5 / -1.0, checksum 0x81
    send_frame(32'h00018000, 32'hFFFF0000, 8'h81);
    chk("a_fixcnt",   fix_cnt, 32'd1);
    chk("a_lat",      gps_lat, 32'h00018000);
    chk("a_lon",      gps_lon, 32'hFFFF0000);
    chk("a_stale",    {31'b0, stale}, 32'h0);
    chk("a_stalefix", {31'b0, stale_at_fix}, 32'h0);
    chk("a_err",      {24'b0, frame_err_cnt}, 32'h0);

    // Bad checksum, then good frame B (checksum 0x08)
    send_frame(32'h00018000, 32'hFFFF0000, 8'h80);
    chk("bcs_fixcnt", fix_cnt, 32'd1);
    chk("bcs_err",    {24'b0, frame_err_cnt}, 32'd1);
    chk("bcs_lat",    gps_lat, 32'h00018000);
    send_frame(32'h12345678, 32'hFEDCBA98, 8'h08);
    chk("b_fixcnt",   fix_cnt, 32'd2);
    chk("b_lat",      gps_lat, 32'h12345678);
    chk("b_lon",      gps_lon, 32'hFEDCBA98);
    chk("b_err",      {24'b0, frame_err_cnt}, 32'd1);

    // Junk 12 A5 then A5 5A 08 ... frame C (checksum 0x83)
    send_byte(8'h12, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_frame(32'hFFFE8000, 32'h00020000, 8'h83);
    chk("c_fixcnt",   fix_cnt, 32'd3);
    chk("c_lat",      gps_lat, 32'hFFFE8000);
    chk("c_lon",      gps_lon, 32'h00020000);
    chk("c_err",      {24'b0, frame_err_cnt}, 32'd1);

    // Wrong length, then frame A accepted straight away
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h07, 1'b1);
    repeat (3) @(negedge clk);
    chk("len_err",    {24'b0, frame_err_cnt}, 32'd2);
    send_frame(32'h00018000, 32'hFFFF0000, 8'h81);
    chk("len_fixcnt", fix_cnt, 32'd4);
    chk("len_lat",    gps_lat, 32'h00018000);

    // Stop bit low inside payload, then frame B
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b0);
    repeat (3) @(negedge clk);
    chk("stop_err",    {24'b0, frame_err_cnt}, 32'd3);
    chk("stop_fixcnt", fix_cnt, 32'd4);
    send_frame(32'h12345678, 32'hFEDCBA98, 8'h08);
    chk("stop2_fixcnt", fix_cnt, 32'd5);
    chk("stop2_lat",    gps_lat, 32'h12345678);

    // Inter-byte timeout after 4 payload bytes, then frame C
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    repeat (201) @(negedge clk);
    chk("tmo_err",    {24'b0, frame_err_cnt}, 32'd4);
    chk("tmo_fixcnt", fix_cnt, 32'd5);
    send_frame(32'hFFFE8000, 32'h00020000, 8'h83);
    chk("tmo2_fixcnt", fix_cnt, 32'd6);
    chk("tmo2_lat",    gps_lat, 32'hFFFE8000);
    chk("tmo2_lon",    gps_lon, 32'h00020000);
    chk("tmo2_err",    {24'b0, frame_err_cnt}, 32'd4);

    // One-cycle low glitch on an idle line
    rx_i = 1'b0;
    @(negedge clk);
    rx_i = 1'b1;
    repeat (60) @(negedge clk);
    chk("gl_err",    {24'b0, frame_err_cnt}, 32'd4);
    chk("gl_fixcnt", fix_cnt, 32'd6);

    // Stale flag reasserts exactly STALE_CYCLES after the fix pulse
    send_frame(32'h00018000, 32'hFFFF0000, 8'h81);
    chk("st_fixcnt", fix_cnt, 32'd7);
    chk("st_low",    {31'b0, stale}, 32'h0);
    repeat (1010) @(negedge clk);
    chk("st_high",   {31'b0, stale}, 32'h1);
    chk("st_gap",    rise_cyc - fix_cyc, 32'd1000);

    // Reset in the middle of a payload
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rr_lat",   gps_lat, 32'h0);
    chk("rr_lon",   gps_lon, 32'h0);
    chk("rr_fix",   {31'b0, fix_valid}, 32'h0);
    chk("rr_stale", {31'b0, stale}, 32'h1);
    chk("rr_err",   {24'b0, frame_err_cnt}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rr_fixcnt", fix_cnt, 32'd7);
    send_frame(32'h12345678, 32'hFEDCBA98, 8'h08);
    chk("rr2_fixcnt", fix_cnt, 32'd8);
    chk("rr2_lat",    gps_lat, 32'h12345678);
    chk("rr2_lon",    gps_lon, 32'hFEDCBA98);
    chk("rr2_err",    {24'b0, frame_err_cnt}, 32'h0);

    // Error counter saturation: 250 bad bytes, then 50 more
    repeat (250) send_byte(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("sat_250", {24'b0, frame_err_cnt}, 32'd250);
    repeat (50) send_byte(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("sat_255",    {24'b0, frame_err_cnt}, 32'd255);
    chk("sat_fixcnt", fix_cnt, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
